instruction_fetch_queue: RTL and testbench



---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/instruction_fetch_queue.sv | 113 +++++++++++
 tb/tb_instruction_fetch_queue.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch queue
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with clear, used for pending PCs and the decode queue
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_head_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign o_head_data = r_mem[r_rd_ptr];

    // A pop frees the slot the same-cycle push may land in.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - credit-based in-order instruction fetch with decode queue and flush
module instruction_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_pc_in,
    output logic            o_pc_take,
    input  logic            i_flush,
    output logic            o_imem_req_valid,
    output logic [XLEN-1:0] o_imem_req_addr,
    input  logic            i_imem_req_ready,
    input  logic            i_imem_resp_valid,
    input  logic [XLEN-1:0] i_imem_resp_data,
    output logic            o_dec_valid,
    output logic [XLEN-1:0] o_dec_pc,
    output logic [XLEN-1:0] o_dec_instr,
    input  logic            i_dec_ready,
    output logic            o_misaligned
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]     w_inflight;
    logic [CW-1:0]     w_qcount;
    logic [CW-1:0]     r_discard;
    logic              r_misaligned;
    logic [CW:0]       w_used;
    logic              w_credit;
    logic              w_aligned;
    logic              w_pend_full;
    logic              w_pend_empty;
    logic [XLEN-1:0]   w_resp_pc;
    logic              w_q_push;
    logic              w_q_pop;
    logic              w_q_full;
    logic              w_q_empty;
    logic [2*XLEN-1:0] w_q_head;

    // In-flight slots count against the queue so every issued fetch has a home.
    assign w_used    = {1'b0, w_inflight} + {1'b0, w_qcount};
    assign w_credit  = (w_used < (CW+1)'(DEPTH));
    assign w_aligned = (i_pc_in[1:0] == 2'b00);

    assign o_imem_req_valid = ~i_reset & ~i_flush & ~r_misaligned & w_aligned & w_credit;
    assign o_pc_take        = o_imem_req_valid & i_imem_req_ready;
    assign o_imem_req_addr  = i_pc_in;

    assign w_q_push = i_imem_resp_valid & ~i_flush & (r_discard == '0);
    assign w_q_pop  = o_dec_valid & i_dec_ready;

    assign o_dec_valid  = ~w_q_empty;
    assign o_dec_pc     = w_q_head[2*XLEN-1:XLEN];
    assign o_dec_instr  = w_q_head[XLEN-1:0];
    assign o_misaligned = r_misaligned;

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pending_pc (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_push      (o_pc_take),
        .i_push_data (i_pc_in),
        .i_pop       (i_imem_resp_valid),
        .i_clear     (1'b0),
        .o_head_data (w_resp_pc),
        .o_full      (w_pend_full),
        .o_empty     (w_pend_empty),
        .o_count     (w_inflight)
    );

    fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_instr_queue (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_push      (w_q_push),
        .i_push_data ({w_resp_pc, i_imem_resp_data}),
        .i_pop       (w_q_pop),
        .i_clear     (i_flush),
        .o_head_data (w_q_head),
        .o_full      (w_q_full),
        .o_empty     (w_q_empty),
        .o_count     (w_qcount)
    );

    // Responses still owed for pre-redirect requests are counted off and dropped.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_discard <= '0;
        end else if (i_flush) begin
            r_discard <= w_inflight - CW'(i_imem_resp_valid);
        end else if (i_imem_resp_valid && (r_discard != '0)) begin
            r_discard <= r_discard - CW'(1);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_misaligned <= 1'b0;
        end else if (i_flush) begin
            r_misaligned <= 1'b0;
        end else if (!w_aligned) begin
            r_misaligned <= 1'b1;
        end
    end

    a_resp_needs_inflight: assert property (@(posedge i_clock) disable iff (i_reset)
        !(i_imem_resp_valid && w_pend_empty));

    a_no_overflow: assert property (@(posedge i_clock) disable iff (i_reset)
        !((w_q_push && w_q_full && !w_q_pop) || (o_pc_take && w_pend_full)));

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - randomized and directed bench for instruction_fetch_queue
`timescale 1ns/1ps
module tb_instruction_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        flush;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        dec_ready;
    logic        pc_take;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        misaligned;

    instruction_fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .i_clock           (clk),
        .i_reset           (rst),
        .i_pc_in           (pc_in),
        .o_pc_take         (pc_take),
        .i_flush           (flush),
        .o_imem_req_valid  (req_valid),
        .o_imem_req_addr   (req_addr),
        .i_imem_req_ready  (req_ready),
        .i_imem_resp_valid (resp_valid),
        .i_imem_resp_data  (resp_data),
        .o_dec_valid       (dec_valid),
        .o_dec_pc          (dec_pc),
        .o_dec_instr       (dec_instr),
        .i_dec_ready       (dec_ready),
        .o_misaligned      (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: memory pipe of accepted reads (doomed = owed to a pre-flush request) and decode queue.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          due;
        bit          doomed;
    } mreq_t;

    mreq_t        pipe[$];
    fetch_entry_t q[$];
    bit           m_mis;
    bit           m_take;
    int           cyc;
    int           lat;
    logic [31:0]  salt;
    int           n_cmp;
    int           n_bad;

    logic         obs_take, obs_req, obs_dv, obs_mis;
    logic [31:0]  obs_pc, obs_instr;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return (pc * 32'd2654435761) ^ salt;
    endfunction

    task automatic apply_reset();
        rst        = 1'b1;
        pc_in      = '0;
        flush      = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = NOP_INSTR;
        dec_ready  = 1'b0;
        pipe.delete();
        q.delete();
        m_mis  = 1'b0;
        m_take = 1'b0;
        salt   = $urandom;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_cycle(input logic [31:0] pc, input logic fl, input logic rdy,
                             input logic mready, input string tag);
        bit          resp;
        bit          exp_req;
        mreq_t       r;
        pc_in     = pc;
        flush     = fl;
        dec_ready = rdy;
        req_ready = mready;
        resp      = (pipe.size() > 0) && (pipe[0].due == cyc);
        resp_valid = resp;
        resp_data  = resp ? pipe[0].instr : NOP_INSTR;
        #2;
        obs_take = pc_take; obs_req = req_valid; obs_dv = dec_valid;
        obs_pc = dec_pc; obs_instr = dec_instr; obs_mis = misaligned;
        exp_req = !fl && !m_mis && (pc[1:0] == 2'b00) && (pipe.size() + q.size() < DEPTH);
        m_take  = exp_req && mready;
        n_cmp++;
        if (obs_req !== exp_req) begin
            n_bad++; $display("FAIL %s c%0d req_valid got %b exp %b", tag, cyc, obs_req, exp_req);
        end
        n_cmp++;
        if (obs_take !== m_take) begin
            n_bad++; $display("FAIL %s c%0d pc_take got %b exp %b", tag, cyc, obs_take, m_take);
        end
        if (exp_req) begin
            n_cmp++;
            if (req_addr !== pc) begin
                n_bad++; $display("FAIL %s c%0d req_addr got %h exp %h", tag, cyc, req_addr, pc);
            end
        end
        n_cmp++;
        if (obs_dv !== (q.size() > 0)) begin
            n_bad++; $display("FAIL %s c%0d dec_valid got %b exp %b", tag, cyc, obs_dv, q.size() > 0);
        end
        if (q.size() > 0) begin
            n_cmp++;
            if (obs_pc !== q[0].pc || obs_instr !== q[0].instr) begin
                n_bad++;
                $display("FAIL %s c%0d dec got {%h,%h} exp {%h,%h}", tag, cyc, obs_pc, obs_instr,
                         q[0].pc, q[0].instr);
            end
        end
        n_cmp++;
        if (obs_mis !== m_mis) begin
            n_bad++; $display("FAIL %s c%0d misaligned got %b exp %b", tag, cyc, obs_mis, m_mis);
        end
        if (resp) r = pipe.pop_front();
        if (fl) begin
            q.delete();
            foreach (pipe[i]) pipe[i].doomed = 1'b1;
            m_mis = 1'b0;
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (resp && !r.doomed) q.push_back('{pc: r.pc, instr: r.instr});
            if (pc[1:0] != 2'b00) m_mis = 1'b1;
        end
        if (m_take) pipe.push_back('{pc: pc, instr: instr_of(pc), due: cyc + lat, doomed: 1'b0});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_in = '0; flush = 0; req_ready = 1; resp_valid = 0;
        resp_data = NOP_INSTR; dec_ready = 1;
        @(posedge clk); #1;
        n_cmp++;
        if ({dec_valid, req_valid, pc_take, misaligned} !== 4'b0000 || dec_pc !== '0 || dec_instr !== '0) begin
            n_bad++;
            $display("FAIL reset outputs got dv=%b rv=%b take=%b mis=%b pc=%h instr=%h exp all 0",
                     dec_valid, req_valid, pc_take, misaligned, dec_pc, dec_instr);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] pc;
        apply_reset(); lat = 1; pc = '0;
        for (int c = 0; c < 6; c++) begin
            run_cycle(pc, 1'b0, 1'b1, 1'b1, "stream");
            if (c < 3) begin
                n_cmp++;
                if (obs_take !== 1'b1) begin
                    n_bad++; $display("FAIL stream_take c%0d got %b exp 1", c, obs_take);
                end
            end
            if (c >= 2 && c <= 4) begin
                n_cmp++;
                if (obs_dv !== 1'b1 || obs_pc !== 32'(4*(c-2)) || obs_instr !== instr_of(32'(4*(c-2)))) begin
                    n_bad++;
                    $display("FAIL stream_dec c%0d got %b{%h,%h} exp 1{%h,%h}", c, obs_dv, obs_pc,
                             obs_instr, 32'(4*(c-2)), instr_of(32'(4*(c-2))));
                end
            end
            if (m_take) pc += 4;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pc;
        int          takes;
        apply_reset(); lat = 1; pc = '0; takes = 0;
        for (int c = 0; c < 8; c++) begin
            run_cycle(pc, 1'b0, 1'b0, 1'b1, "bp");
            takes += int'(obs_take);
            if (m_take) pc += 4;
        end
        n_cmp++;
        if (takes != DEPTH || obs_req !== 1'b0) begin
            n_bad++; $display("FAIL bp_credit takes got %0d req=%b exp %0d req=0", takes, obs_req, DEPTH);
        end
        run_cycle(pc, 1'b0, 1'b1, 1'b1, "bp");
        if (m_take) pc += 4;
        run_cycle(pc, 1'b0, 1'b0, 1'b1, "bp");
        n_cmp++;
        if (obs_take !== 1'b1) begin
            n_bad++; $display("FAIL bp_release take got %b exp 1", obs_take);
        end
        if (m_take) pc += 4;
        run_cycle(pc, 1'b0, 1'b0, 1'b1, "bp");
        n_cmp++;
        if (obs_take !== 1'b0) begin
            n_bad++; $display("FAIL bp_refull take got %b exp 0", obs_take);
        end
    endtask

    task automatic test_flush_inflight();
        logic [31:0] pc;
        bit          seen;
        apply_reset(); lat = 3; pc = '0; seen = 0;
        for (int c = 0; c < 3; c++) begin
            run_cycle(pc, 1'b0, 1'b1, 1'b1, "flush3");
            if (m_take) pc += 4;
        end
        pc = 32'h100;
        run_cycle(pc, 1'b1, 1'b1, 1'b1, "flush3");
        for (int c = 0; c < 12 && !seen; c++) begin
            run_cycle(pc, 1'b0, 1'b1, 1'b1, "flush3");
            if (obs_dv === 1'b1) begin
                seen = 1;
                n_cmp++;
                if (obs_pc !== 32'h100) begin
                    n_bad++; $display("FAIL flush3_first dec_pc got %h exp 00000100", obs_pc);
                end
            end
            if (m_take) pc += 4;
        end
        if (!seen) begin
            n_cmp++; n_bad++; $display("FAIL flush3_timeout dec_valid got 0 exp 1 within 12 cycles");
        end
    endtask

    task automatic test_flush_with_resp();
        logic [31:0] pc;
        apply_reset(); lat = 2; pc = '0;
        for (int c = 0; c < 4; c++) begin
            run_cycle(pc, 1'b0, 1'b0, 1'b1, "flushresp");
            if (m_take) pc += 4;
        end
        pc = 32'h200;
        run_cycle(pc, 1'b1, 1'b1, 1'b1, "flushresp");
        n_cmp++;
        if (obs_dv !== 1'b1) begin
            n_bad++; $display("FAIL flushresp_pre dec_valid got %b exp 1", obs_dv);
        end
        for (int c = 0; c < 4; c++) begin
            run_cycle(pc, 1'b0, 1'b1, 1'b1, "flushresp");
            if (c < 2) begin
                n_cmp++;
                if (obs_dv !== 1'b0) begin
                    n_bad++; $display("FAIL flushresp_drop c%0d dec_valid got %b exp 0", c, obs_dv);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if (obs_dv !== 1'b1 || obs_pc !== 32'h200) begin
                    n_bad++; $display("FAIL flushresp_target got %b/%h exp 1/00000200", obs_dv, obs_pc);
                end
            end
            if (m_take) pc += 4;
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] pc;
        apply_reset(); lat = 1; pc = '0;
        for (int c = 0; c < 2; c++) begin
            run_cycle(pc, 1'b0, 1'b0, 1'b1, "mis");
            if (m_take) pc += 4;
        end
        pc = 32'h6;
        for (int c = 0; c < 4; c++) begin
            run_cycle(pc, 1'b0, 1'b0, 1'b1, "mis");
            n_cmp++;
            if (obs_req !== 1'b0 || (c > 0 && obs_mis !== 1'b1)) begin
                n_bad++; $display("FAIL mis_hold c%0d req=%b mis=%b exp req=0 mis=1", c, obs_req, obs_mis);
            end
        end
        for (int c = 0; c < 2; c++) begin
            run_cycle(pc, 1'b0, 1'b1, 1'b1, "mis");
            n_cmp++;
            if (obs_dv !== 1'b1 || obs_pc !== 32'(4*c)) begin
                n_bad++; $display("FAIL mis_drain c%0d got %b/%h exp 1/%h", c, obs_dv, obs_pc, 32'(4*c));
            end
        end
        pc = 32'h300;
        run_cycle(pc, 1'b1, 1'b1, 1'b1, "mis");
        run_cycle(pc, 1'b0, 1'b1, 1'b1, "mis");
        n_cmp++;
        if (obs_mis !== 1'b0 || obs_take !== 1'b1) begin
            n_bad++; $display("FAIL mis_clear mis=%b take=%b exp mis=0 take=1", obs_mis, obs_take);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] pc;
        apply_reset(); lat = 2; pc = '0;
        for (int c = 0; c < 5; c++) begin
            run_cycle(pc, 1'b0, 1'b0, 1'b1, "rstmid");
            if (m_take) pc += 4;
        end
        n_cmp++;
        if (obs_dv !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_pre dec_valid got %b exp 1", obs_dv);
        end
        pc_in = 32'h40; resp_valid = 1'b0; req_ready = 1'b1;
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (dec_valid !== 1'b0 || req_valid !== 1'b0 || pc_take !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_async dv=%b rv=%b take=%b exp 0 0 0", dec_valid, req_valid, pc_take);
        end
        pipe.delete(); q.delete(); m_mis = 1'b0;
        @(posedge clk); #1 rst = 1'b0; cyc = 0;
        pc = 32'h400;
        for (int c = 0; c < 5; c++) begin
            run_cycle(pc, 1'b0, 1'b1, 1'b1, "rstmid");
            if (c == 0) begin
                n_cmp++;
                if (obs_take !== 1'b1 || obs_dv !== 1'b0) begin
                    n_bad++; $display("FAIL rstmid_restart take=%b dv=%b exp 1 0", obs_take, obs_dv);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if (obs_dv !== 1'b1 || obs_pc !== 32'h400) begin
                    n_bad++; $display("FAIL rstmid_first got %b/%h exp 1/00000400", obs_dv, obs_pc);
                end
            end
            if (m_take) pc += 4;
        end
    endtask

    task automatic test_random();
        logic [31:0] pc;
        logic [31:0] pc_t;
        logic        fl;
        for (int l = 1; l <= 3; l++) begin
            apply_reset(); lat = l; pc = '0;
            for (int c = 0; c < 300; c++) begin
                fl = ($urandom_range(0, 99) < 6);
                pc_t = $urandom;
                pc_t[1:0] = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00;
                if (fl) pc = pc_t;
                run_cycle(pc, fl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), "random");
                if (m_take) pc += 4;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; lat = 1; salt = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_inflight();
        test_flush_with_resp();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
